issue_unit: RTL and testbench
=============================

Name: issue_unit

Overview:
- Scheduler between the four per-class reservation stations and their functional units (FUs).
- Each cycle it grants every RS whose head candidate is ready and whose FU can accept work, and pulses that RS's clear with the candidate tag.
- It starts the FU one cycle later, aligned with the RS's registered insn_for_ex.
- It tracks per-FU latency and occupancy, then drives the 4-lane wakeup bus (valid/tag/value) that feeds every RS.

Parameters:
- MULT_LAT, 4, multiplier latency in cycles; legal range 1..15. The multiplier is non-pipelined.
- CNT_W, 4, width of the multiplier down-counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rs_valid  in  [3:0]  RS has a ready candidate. Lane order everywhere: 0=LSU, 1=MULT, 2=BTU, 3=ALU.
- rs_tag  in  [3:0][`ROB_TAG_LEN-1:0]  candidate tag per lane
- fu_result  in  [3:0][`XLEN-1:0]  FU result per lane; sampled as defined below
- lsu_done  in  1  LSU completion strobe; fu_result[0] is valid in the same cycle
- flush  in  1  squash all in-flight work (mispredict)
- rs_clear  out  [3:0]  combinational grant / clear to each RS
- rs_clear_tag  out  [3:0][`ROB_TAG_LEN-1:0]  tag to clear, equals rs_tag of that lane
- fu_start  out  [3:0]  registered one-cycle start pulse to each FU
- fu_busy  out  [3:0]  registered occupancy state per FU
- wakeup  out  [3:0]  registered broadcast valid
- wakeup_tag  out  [3:0][`ROB_TAG_LEN-1:0]
- wakeup_value  out  [3:0][`XLEN-1:0]

Behaviour:
- Reset (async, reset_n=0): all registered outputs and internal state go to 0. rs_clear=0 while reset_n=0. The block is usable on the first clk edge after deassertion.
- Grant (combinational) in cycle N: rs_clear[j] = rs_valid[j] & ~flush & can_accept[j]. rs_clear_tag[j] = rs_tag[j] always.
- can_accept, per lane:
  - ALU, BTU: always 1 (pipelined, latency 1).
  - MULT: ~fu_busy[1] | (mult_cnt==1).
  - LSU: ~fu_busy[0] | lsu_done.
- Start: fu_start[j] = 1 in cycle N+1 exactly when rs_clear[j]=1 in cycle N. The granted tag is captured into a per-lane in-flight register.
- ALU/BTU: fu_result sampled at end of N+1. Outputs in N+2: wakeup[j]=1, wakeup_tag = granted tag, wakeup_value = sample. A grant is allowed every cycle, giving back-to-back wakeups.
- MULT FSM, IDLE/EXEC with down-counter:
  - On grant, in N+1: mult_cnt=MULT_LAT; fu_busy[1]=1 iff MULT_LAT>1.
  - mult_cnt decrements each cycle.
  - Result sampled at end of N+MULT_LAT; wakeup in N+MULT_LAT+1.
  - fu_busy[1] is high for cycles N+1..N+MULT_LAT-1. A new grant is legal in N+MULT_LAT.
  - MULT_LAT=1 behaves exactly like the ALU.
- LSU FSM, IDLE/WAIT:
  - Grant moves to WAIT with fu_busy[0]=1 from N+1.
  - lsu_done in cycle D≥N+1 → wakeup[0] in D+1 with fu_result[0] sampled at D. Return to IDLE unless a same-cycle grant occurs (then stay WAIT with the new tag).
  - lsu_done in IDLE, or in cycle N (before start), is ignored.
- Wakeup is a single-cycle pulse per completion; lanes are independent, so up to 4 wakeups may occur in one cycle.
- Flush in cycle F:
  - rs_clear=0 in F.
  - In F+1: fu_start=0, wakeup=0, fu_busy=0, all FSMs IDLE, counters 0.
  - Completions that were due in F+1 are dropped.
  - A flush coinciding with lsu_done suppresses that wakeup.
- Value width: wakeup_value is the full XLEN; tags pass through unmodified, with no arithmetic on tags.

Decomposition:
- Shared package (sys_defs.svh / reservation_station.svh):
  - FU_IDX enum {FU_LSU=0, FU_MULT=1, FU_BTU=2, FU_ALU=3}
  - NUM_FU=4
  - ISSUE_MULT_LAT default
  - Existing `XLEN and `ROB_TAG_LEN
- Sub-module fu_tracker (one instance per lane), parameterised by LATENCY and VARIABLE (LSU mode).
  - Holds the in-flight tag, counter and FSM.
  - Produces can_accept, fu_start, fu_busy, wakeup, wakeup_tag and wakeup_value.
- issue_unit handles grant gating and flush fan-out.

Test Plan:
- Reset mid-op: grant MULT with tag 5, drop reset_n asynchronously two cycles later → all outputs 0 immediately; no wakeup for tag 5 after release.
- ALU back-to-back: rs_valid[3] with tags 3, 4, 5 in N..N+2, fu_result 0x10/0x20/0x30 → rs_clear[3] in N..N+2, fu_start[3] in N+1..N+3, wakeup[3] with (3,0x10), (4,0x20), (5,0x30) in N+2..N+4.
- MULT occupancy, MULT_LAT=4: tag 7 granted at N, tag 8 valid throughout → rs_clear[1] only at N and N+4; wakeup[1] tag 7 at N+5, tag 8 at N+9.
- LSU variable latency: tag 9 granted at N, lsu_done at N+6 with value 0xDEAD and tag 10 valid → tag 10 granted at N+6; wakeup[0] (9, 0xDEAD) at N+7; fu_busy[0] stays 1.
- Flush: ALU tag 2 granted at F-1, MULT busy, flush at F with rs_valid all 1 → rs_clear=0 at F; wakeup=0 and fu_busy=0 at F+1; tag 2 never broadcast.
- Simultaneous: all four lanes complete in the same cycle → four wakeups asserted together, each with the correct tag and value.

Source files
------------

// File: rtl/issue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : issue_unit_pkg
// Brief    : Shared widths, lane indices and defaults for the issue unit.
// Revision : 1.0 - initial release
// ============================================================================
package issue_unit_pkg;

    localparam int XLEN           = 32;
    localparam int ROB_TAG_LEN    = 6;
    localparam int NUM_FU         = 4;
    localparam int ISSUE_MULT_LAT = 4;

    // Lane order used on every per-FU bus.
    typedef enum logic [1:0] {
        FU_LSU  = 2'd0,
        FU_MULT = 2'd1,
        FU_BTU  = 2'd2,
        FU_ALU  = 2'd3
    } fu_idx_e;

endpackage
`default_nettype wire

// File: rtl/issue_unit_fu_tracker.sv
`default_nettype none
// ============================================================================
// Module   : issue_unit_fu_tracker
// Brief    : Per-FU in-flight tracker (fixed latency or LSU done-driven).
// Revision : 1.0 - initial release
// ============================================================================
module issue_unit_fu_tracker
    import issue_unit_pkg::*;
#(
    parameter int LATENCY  = 1,
    parameter bit VARIABLE = 1'b0,
    parameter int CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   grant,
    input  logic [ROB_TAG_LEN-1:0] grant_tag,
    input  logic [XLEN-1:0]        result,
    input  logic                   done,
    output logic                   can_accept,
    output logic                   fu_start,
    output logic                   fu_busy,
    output logic                   wakeup,
    output logic [ROB_TAG_LEN-1:0] wakeup_tag,
    output logic [XLEN-1:0]        wakeup_value
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_EXEC = 1'b1;

    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic                   r_start;
    logic [ROB_TAG_LEN-1:0] r_tag;
    logic                   r_wakeup;
    logic [ROB_TAG_LEN-1:0] r_wakeup_tag;
    logic [XLEN-1:0]        r_wakeup_value;
    logic                   w_complete;

    // Fixed-latency units finish when the counter reaches 1; the LSU finishes on done.
    assign w_complete = (r_state == c_ST_EXEC) &
                        (VARIABLE ? done : (r_cnt == CNT_W'(1)));

    assign can_accept = VARIABLE ? (~r_busy | done) : (~r_busy | (r_cnt == CNT_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_start        <= 1'b0;
            r_tag          <= '0;
            r_wakeup       <= 1'b0;
            r_wakeup_tag   <= '0;
            r_wakeup_value <= '0;
        end else if (flush) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_start        <= 1'b0;
            r_tag          <= '0;
            r_wakeup       <= 1'b0;
            r_wakeup_tag   <= '0;
            r_wakeup_value <= '0;
        end else begin
            r_start  <= grant;
            r_wakeup <= w_complete;
            if (w_complete) begin
                r_wakeup_tag   <= r_tag;
                r_wakeup_value <= result;
            end
            if (grant) begin
                r_state <= c_ST_EXEC;
                r_tag   <= grant_tag;
                r_cnt   <= VARIABLE ? '0 : CNT_W'(LATENCY);
                r_busy  <= VARIABLE ? 1'b1 : (LATENCY > 1);
            end else if (w_complete) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else if (!VARIABLE && (r_state == c_ST_EXEC)) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_busy <= (r_cnt > CNT_W'(2));
            end
        end
    end

    assign fu_start     = r_start;
    assign fu_busy      = r_busy;
    assign wakeup       = r_wakeup;
    assign wakeup_tag   = r_wakeup_tag;
    assign wakeup_value = r_wakeup_value;

endmodule
`default_nettype wire

// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : issue_unit
// Brief    : Grants ready RS heads to free FUs and drives the wakeup bus.
// Revision : 1.0 - initial release
// ============================================================================
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int MULT_LAT = ISSUE_MULT_LAT,
    parameter int CNT_W    = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_FU-1:0]                   rs_valid,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  rs_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]         fu_result,
    input  logic                                lsu_done,
    input  logic                                flush,
    output logic [NUM_FU-1:0]                   rs_clear,
    output logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  rs_clear_tag,
    output logic [NUM_FU-1:0]                   fu_start,
    output logic [NUM_FU-1:0]                   fu_busy,
    output logic [NUM_FU-1:0]                   wakeup,
    output logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  wakeup_tag,
    output logic [NUM_FU-1:0][XLEN-1:0]         wakeup_value
);

    logic [NUM_FU-1:0] w_can_accept;

    // Reset is folded in so no RS entry is cleared while the trackers are held.
    assign rs_clear     = rs_valid & w_can_accept & {NUM_FU{~flush & reset_n}};
    assign rs_clear_tag = rs_tag;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        issue_unit_fu_tracker #(
            .LATENCY  ((i == int'(FU_MULT)) ? MULT_LAT : 1),
            .VARIABLE (i == int'(FU_LSU)),
            .CNT_W    (CNT_W)
        ) u_tracker (
            .clk          (clk),
            .reset_n      (reset_n),
            .flush        (flush),
            .grant        (rs_clear[i]),
            .grant_tag    (rs_tag[i]),
            .result       (fu_result[i]),
            .done         ((i == int'(FU_LSU)) ? lsu_done : 1'b0),
            .can_accept   (w_can_accept[i]),
            .fu_start     (fu_start[i]),
            .fu_busy      (fu_busy[i]),
            .wakeup       (wakeup[i]),
            .wakeup_tag   (wakeup_tag[i]),
            .wakeup_value (wakeup_value[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_unit
// Brief    : Directed, table-driven bench for issue_unit (MULT_LAT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_unit;
    import issue_unit_pkg::*;

    typedef logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] tags_t;
    typedef logic [NUM_FU-1:0][XLEN-1:0]        vals_t;

    typedef struct {
        logic [3:0] valid;
        tags_t      tag;
        vals_t      res;
        logic       done;
        logic       flush;
        logic [3:0] e_clear;
        logic [3:0] e_start;
        logic [3:0] e_busy;
        logic [3:0] e_wake;
        tags_t      e_tag;
        vals_t      e_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  rs_valid;
    tags_t       rs_tag;
    vals_t       fu_result;
    logic        lsu_done;
    logic        flush;
    logic [3:0]  rs_clear;
    tags_t       rs_clear_tag;
    logic [3:0]  fu_start;
    logic [3:0]  fu_busy;
    logic [3:0]  wakeup;
    tags_t       wakeup_tag;
    vals_t       wakeup_value;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    issue_unit #(.MULT_LAT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rs_valid     (rs_valid),
        .rs_tag       (rs_tag),
        .fu_result    (fu_result),
        .lsu_done     (lsu_done),
        .flush        (flush),
        .rs_clear     (rs_clear),
        .rs_clear_tag (rs_clear_tag),
        .fu_start     (fu_start),
        .fu_busy      (fu_busy),
        .wakeup       (wakeup),
        .wakeup_tag   (wakeup_tag),
        .wakeup_value (wakeup_value)
    );

    function automatic tags_t T(input int t3, input int t2, input int t1, input int t0);
        tags_t r;
        r[3] = t3[ROB_TAG_LEN-1:0];
        r[2] = t2[ROB_TAG_LEN-1:0];
        r[1] = t1[ROB_TAG_LEN-1:0];
        r[0] = t0[ROB_TAG_LEN-1:0];
        return r;
    endfunction

    function automatic vals_t V(input logic [31:0] v3, input logic [31:0] v2,
                                input logic [31:0] v1, input logic [31:0] v0);
        vals_t r;
        r[3] = v3;
        r[2] = v2;
        r[1] = v1;
        r[0] = v0;
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] valid, input tags_t tag, input vals_t res,
                                input logic done, input logic fl,
                                input logic [3:0] ec, input logic [3:0] es,
                                input logic [3:0] eb, input logic [3:0] ew,
                                input tags_t etag, input vals_t eval);
        vec_t r;
        r.valid = valid; r.tag = tag; r.res = res; r.done = done; r.flush = fl;
        r.e_clear = ec; r.e_start = es; r.e_busy = eb; r.e_wake = ew;
        r.e_tag = etag; r.e_val = eval;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, want %0h", name, row, act, exp);
        end
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk("rs_clear", i, rs_clear, v.e_clear);
        chk("rs_clear_tag", i, rs_clear_tag, v.tag);
        chk("fu_start", i, fu_start, v.e_start);
        chk("fu_busy", i, fu_busy, v.e_busy);
        chk("wakeup", i, wakeup, v.e_wake);
        for (int j = 0; j < NUM_FU; j++) begin
            if (v.e_wake[j]) begin
                chk("wakeup_tag", i, wakeup_tag[j], v.e_tag[j]);
                chk("wakeup_value", i, wakeup_value[j], v.e_val[j]);
            end
        end
    endtask

    task automatic check_all_zero(input int i);
        chk("rst rs_clear", i, rs_clear, 0);
        chk("rst fu_start", i, fu_start, 0);
        chk("rst fu_busy", i, fu_busy, 0);
        chk("rst wakeup", i, wakeup, 0);
        chk("rst wakeup_tag", i, wakeup_tag, 0);
        chk("rst wakeup_value", i, wakeup_value, 0);
    endtask

    initial begin
        tags_t Z;
        vals_t Y;
        Z = '0;
        Y = '0;

        // ALU back-to-back: tags 3,4,5
        tbl.push_back(mk(4'b1000, T(3,0,0,0), Y,                     0,0, 4'b1000,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b1000, T(4,0,0,0), V(32'h10,0,0,0),       0,0, 4'b1000,4'b1000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b1000, T(5,0,0,0), V(32'h20,0,0,0),       0,0, 4'b1000,4'b1000,4'b0000,4'b1000, T(3,0,0,0), V(32'h10,0,0,0)));
        tbl.push_back(mk(4'b0000, Z,          V(32'h30,0,0,0),       0,0, 4'b0000,4'b1000,4'b0000,4'b1000, T(4,0,0,0), V(32'h20,0,0,0)));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b1000, T(5,0,0,0), V(32'h30,0,0,0)));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        // MULT occupancy: tag 7 at N, tag 8 waits until N+4
        tbl.push_back(mk(4'b0010, T(0,0,7,0), Y,                     0,0, 4'b0010,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0010, T(0,0,8,0), Y,                     0,0, 4'b0000,4'b0010,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0010, T(0,0,8,0), Y,                     0,0, 4'b0000,4'b0000,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0010, T(0,0,8,0), Y,                     0,0, 4'b0000,4'b0000,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0010, T(0,0,8,0), V(0,0,32'h77,0),       0,0, 4'b0010,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0010,4'b0010,4'b0010, T(0,0,7,0), V(0,0,32'h77,0)));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          V(0,0,32'h88,0),       0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0010, T(0,0,8,0), V(0,0,32'h88,0)));
        // LSU: done while idle and in the grant cycle are ignored; tag 9 then 10
        tbl.push_back(mk(4'b0000, Z,          V(0,0,0,32'h11),       1,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,9), V(0,0,0,32'h12),       1,0, 4'b0001,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0001,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,10),Y,                     0,0, 4'b0000,4'b0000,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,10),Y,                     0,0, 4'b0000,4'b0000,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,10),Y,                     0,0, 4'b0000,4'b0000,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,10),Y,                     0,0, 4'b0000,4'b0000,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,10),V(0,0,0,32'hDEAD),     1,0, 4'b0001,4'b0000,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0001,4'b0001,4'b0001, T(0,0,0,9), V(0,0,0,32'hDEAD)));
        tbl.push_back(mk(4'b0000, Z,          V(0,0,0,32'hBEEF),     1,0, 4'b0000,4'b0000,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0001, T(0,0,0,10), V(0,0,0,32'hBEEF)));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        // All four lanes complete together
        tbl.push_back(mk(4'b0011, T(0,0,21,20),Y,                    0,0, 4'b0011,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0011,4'b0011,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0011,4'b0000, Z, Y));
        tbl.push_back(mk(4'b1100, T(23,22,0,0),Y,                    0,0, 4'b1100,4'b0000,4'b0011,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z, V(32'hA3,32'hA2,32'hA1,32'hA0), 1,0, 4'b0000,4'b1100,4'b0001,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b1111,
                         T(23,22,21,20), V(32'hA3,32'hA2,32'hA1,32'hA0)));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        // Flush with ALU tag 2 in flight and MULT busy
        tbl.push_back(mk(4'b0010, T(0,0,30,0),Y,                     0,0, 4'b0010,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0010,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b1000, T(2,0,0,0), Y,                     0,0, 4'b1000,4'b0000,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b1111, T(1,2,3,4), V(1,2,3,4),            1,1, 4'b0000,4'b1000,4'b0010,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          V(5,6,7,8),            0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0010, T(0,0,31,0),Y,                     0,0, 4'b0010,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0001, T(0,0,0,11),Y,                     0,0, 4'b0001,4'b0010,4'b0010,4'b0000, Z, Y));
        // Flush coinciding with lsu_done drops the LSU wakeup
        tbl.push_back(mk(4'b0000, Z,          V(0,0,0,32'h55),       1,1, 4'b0000,4'b0001,4'b0011,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));
        tbl.push_back(mk(4'b0000, Z,          Y,                     0,0, 4'b0000,4'b0000,4'b0000,4'b0000, Z, Y));

        // Reset state, with every RS asserting valid
        reset_n   = 1'b0;
        rs_valid  = 4'b1111;
        rs_tag    = T(1,2,3,4);
        fu_result = '0;
        lsu_done  = 1'b1;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero(-1);
        rs_valid = '0;
        lsu_done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rs_valid  = tbl[i].valid;
            rs_tag    = tbl[i].tag;
            fu_result = tbl[i].res;
            lsu_done  = tbl[i].done;
            flush     = tbl[i].flush;
            #3;
            check_row(i, tbl[i]);
        end

        // Asynchronous reset two cycles into a MULT operation
        @(posedge clk);
        #1;
        rs_valid = 4'b0010; rs_tag = T(0,0,5,0); fu_result = '0; lsu_done = 1'b0; flush = 1'b0;
        #3;
        chk("mid rs_clear", 100, rs_clear, 4'b0010);
        @(posedge clk);
        #1;
        rs_valid = 4'b0000;
        #3;
        chk("mid fu_busy", 101, fu_busy, 4'b0010);
        @(posedge clk);
        #1;
        rs_valid  = 4'b1111;
        fu_result = V(9,9,9,9);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero(102);
        rs_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #4;
            chk("post-rst wakeup", 110 + k, wakeup, 4'b0000);
            chk("post-rst fu_busy", 110 + k, fu_busy, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
